// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receive end of the single-wire serial link. Hunts for a start bit (0),
//   shifts in WIDTH data bits LSB first, optionally checks an even-parity bit,
//   then checks the stop bit (1). Good words land in a one-word holding
//   register that is drained through a valid/ready handshake.
//
//   Optional feature macro: SFRX_PARITY_EN
//     defined   : one even-parity bit follows the data bits (frame = WIDTH+3 bits)
//     undefined : no parity bit (frame = WIDTH+2 bits), parity_err tied 0
//
// Ports
//   clk        in   rising-edge clock, d sampled on every edge
//   rest       in   synchronous active-high reset
//   d          in   serial line, idle high
//   data_out   out  [WIDTH-1:0] held word, meaningful while valid=1
//   valid      out  holding register has an unconsumed word
//   ready      in   consumer takes data_out when valid && ready
//   frame_err  out  1-cycle pulse: stop bit sampled as 0
//   overrun    out  1-cycle pulse: good word dropped, holding register full
//   parity_err out  1-cycle pulse: parity mismatch (parity build only)
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             d,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd3;
`ifdef SFRX_PARITY_EN
  localparam logic [1:0] S_PAR  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  // Set on the stop-sample edge of a good frame; the holding register is
  // updated one edge later from the (still intact) shift register.
  logic             good_q, good_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
`ifdef SFRX_PARITY_EN
  logic             parbad_q, parbad_d;
  logic             perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    good_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef SFRX_PARITY_EN
    parbad_d = parbad_q;
    perr_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!d) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        // Write d into bit[cnt]; shift-based masking keeps the index width-safe.
        shift_d = (shift_q & ~(WIDTH'(1) << cnt_q)) | (WIDTH'(d) << cnt_q);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SFRX_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef SFRX_PARITY_EN
      S_PAR: begin
        // Even parity: data ones plus parity bit must be even.
        parbad_d = (^shift_q) ^ d;
        state_d  = S_STOP;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        if (!d) begin
          ferr_d = 1'b1;               // frame error wins over parity error
`ifdef SFRX_PARITY_EN
        end else if (parbad_q) begin
          perr_d = 1'b1;
`endif
        end else begin
          good_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Holding register: a load on the same edge as a consume replaces the word.
    if (good_q) begin
      if (valid_q && !ready) begin
        ovr_d = 1'b1;
      end else begin
        hold_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      good_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SFRX_PARITY_EN
      parbad_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      good_q  <= good_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SFRX_PARITY_EN
      parbad_q <= parbad_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign data_out  = hold_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef SFRX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
